// File: rtl/i4001_rom_if.sv
// rtl/i4001_rom_if.sv - MCS-4 multiplexed bus bundle between the CPU side and a 4001 ROM
// Signals:
//   clk1, clk2  two-phase strobes, already synchronised to the system clock
//   sync        CPU SYNC, high during X3
//   cm_rom      CPU CM-ROM line
//   data_in     bus value seen at the pads
//   data_out    bus value driven by the ROM
//   data_dir    1 = ROM drives the bus
// Modports: master = CPU/pad side, slave = ROM side.
interface i4001_rom_if;
    logic       clk1;
    logic       clk2;
    logic       sync;
    logic       cm_rom;
    logic [3:0] data_in;
    logic [3:0] data_out;
    logic       data_dir;

    modport master (
        output clk1, clk2, sync, cm_rom, data_in,
        input  data_out, data_dir
    );

    modport slave (
        input  clk1, clk2, sync, cm_rom, data_in,
        output data_out, data_dir
    );
endinterface

// File: rtl/i4001_rom.sv
// rtl/i4001_rom.sv - 4001 ROM bus responder: instruction fetch plus SRC/WRR/RDR I/O port
// Ports:
//   sysclk    system clock, all state on posedge
//   poc_n     synchronous active-low reset
//   bus       MCS-4 bus (slave modport): clk1, clk2, sync, cm_rom, data_in, data_out, data_dir
//   rom_addr  byte address to the external synchronous ROM array
//   rom_re    one-sysclk read strobe
//   rom_q     ROM data, valid one sysclk after rom_re
//   io_out    I/O output port, written by WRR
//   io_in     I/O input port, read by RDR
module i4001_rom #(
    parameter logic [3:0] CHIP_ID  = 4'h0,
    parameter logic [3:0] IO_RESET = 4'h0
) (
    input  logic        sysclk,
    input  logic        poc_n,
    i4001_rom_if.slave  bus,
    output logic [7:0]  rom_addr,
    output logic        rom_re,
    input  logic [7:0]  rom_q,
    output logic [3:0]  io_out,
    input  logic [3:0]  io_in
);
    typedef enum logic [3:0] {
        S_UNSYNC, S_A1, S_A2, S_A3, S_M1, S_M2, S_X1, S_X2, S_X3
    } state_t;

    state_t     state, state_nxt;
    logic       clk2_q;
    logic       step;
    logic [3:0] bv;
    logic [3:0] a1, a2, addr_lo;
    logic [3:0] opr, opa;
    logic [7:0] rdat;
    logic       rd_pend;
    logic       sel, io_sel, io_cyc;
    logic [3:0] io_rd;

    // Subcycles advance on the falling edge of clk2.
    assign step = clk2_q && !bus.clk2;
    assign bv   = bus.data_dir ? bus.data_out : bus.data_in;

    // a2 is captured at the same moment as the ROM address high nibble,
    // so it doubles as that nibble; addr_lo freezes a1 for the same read.
    assign rom_addr = {a2, addr_lo};

    always_ff @(posedge sysclk) begin
        if (!poc_n) begin
            state  <= S_UNSYNC;
            clk2_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            clk2_q <= bus.clk2;
        end
    end

    always_comb begin
        state_nxt = state;
        if (step) begin
            if (bus.sync) begin
                state_nxt = S_A1;
            end else begin
                case (state)
                    S_UNSYNC: state_nxt = S_UNSYNC;
                    S_A1:     state_nxt = S_A2;
                    S_A2:     state_nxt = S_A3;
                    S_A3:     state_nxt = S_M1;
                    S_M1:     state_nxt = S_M2;
                    S_M2:     state_nxt = S_X1;
                    S_X1:     state_nxt = S_X2;
                    S_X2:     state_nxt = S_X3;
                    S_X3:     state_nxt = S_A1;
                    default:  state_nxt = S_UNSYNC;
                endcase
            end
        end
    end

    // Drive is decoded from the registered state, so it switches on exactly
    // the step that enters or leaves the driving subcycle.
    always_comb begin
        bus.data_dir = 1'b0;
        bus.data_out = 4'h0;
        case (state)
            S_M1: if (sel) begin
                bus.data_dir = 1'b1;
                bus.data_out = rdat[7:4];
            end
            S_M2: if (sel) begin
                bus.data_dir = 1'b1;
                bus.data_out = rdat[3:0];
            end
            S_X2: if (io_cyc && io_sel && opa == 4'hA) begin
                bus.data_dir = 1'b1;
                bus.data_out = io_rd;
            end
            default: ;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (!poc_n) begin
            a1      <= 4'h0;
            a2      <= 4'h0;
            addr_lo <= 4'h0;
            opr     <= 4'h0;
            opa     <= 4'h0;
            rdat    <= 8'h00;
            rd_pend <= 1'b0;
            rom_re  <= 1'b0;
            sel     <= 1'b0;
            io_sel  <= 1'b0;
            io_cyc  <= 1'b0;
            io_rd   <= 4'h0;
            io_out  <= IO_RESET;
        end else begin
            rom_re  <= 1'b0;
            rd_pend <= rom_re;
            if (rd_pend) begin
                rdat <= rom_q;
            end
            if (step) begin
                case (state)
                    S_A1: a1 <= bv;
                    S_A2: begin
                        a2      <= bv;
                        addr_lo <= a1;
                        rom_re  <= 1'b1;
                    end
                    S_A3: sel <= (bv == CHIP_ID) && bus.cm_rom;
                    S_M1: opr <= bv;
                    S_M2: begin
                        opa    <= bv;
                        io_cyc <= bus.cm_rom && (opr == 4'hE);
                    end
                    // RDR data is frozen on X2 entry so the bus stays stable.
                    S_X1: io_rd <= io_in;
                    S_X2: begin
                        if (bus.cm_rom && !io_cyc) begin
                            io_sel <= (bus.data_in == CHIP_ID);
                        end
                        if (io_cyc && io_sel && opa == 4'h2) begin
                            io_out <= bus.data_in;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i4001_rom.sv
// tb/tb_i4001_rom.sv - directed self-checking bench for i4001_rom
module tb_i4001_rom;
    localparam logic [3:0] CHIP_ID  = 4'h3;
    localparam logic [3:0] IO_RESET = 4'h7;

    logic       sysclk = 1'b0;
    logic       poc_n;
    logic [7:0] rom_addr;
    logic       rom_re;
    logic [7:0] rom_q;
    logic [3:0] io_out;
    logic [3:0] io_in;
    logic [7:0] rom [256];
    int         vecs = 0;
    int         errs = 0;
    int         rom_re_cnt = 0;

    i4001_rom_if bus();

    i4001_rom #(.CHIP_ID(CHIP_ID), .IO_RESET(IO_RESET)) dut (
        .sysclk   (sysclk),
        .poc_n    (poc_n),
        .bus      (bus),
        .rom_addr (rom_addr),
        .rom_re   (rom_re),
        .rom_q    (rom_q),
        .io_out   (io_out),
        .io_in    (io_in)
    );

    always #5 sysclk = ~sysclk;

    always @(posedge sysclk) if (rom_re) rom_q <= rom[rom_addr];
    always @(negedge sysclk) if (rom_re) rom_re_cnt++;

    // One bus subcycle: inputs held, clk1 then clk2 pulse; returns just after the step.
    task automatic sub(input logic s, input logic [3:0] d, input logic cm);
        bus.sync = s; bus.data_in = d; bus.cm_rom = cm;
        bus.clk1 = 1'b1;
        @(negedge sysclk);
        bus.clk1 = 1'b0; bus.clk2 = 1'b1;
        repeat (2) @(negedge sysclk);
        bus.clk2 = 1'b0;
        @(negedge sysclk);
    endtask

    // Whole instruction cycle from A1 back to A1, address 0xC5, chip nibble a3.
    task automatic run_cycle(input logic [3:0] a3, input logic [3:0] m1, input logic [3:0] m2,
                             input logic cm_m2, input logic [3:0] x2, input logic cm_x2);
        sub(0, 4'h5, 0); sub(0, 4'hC, 0); sub(0, a3, 1);
        sub(0, m1, 0); sub(0, m2, cm_m2); sub(0, 4'h0, 0);
        sub(0, x2, cm_x2); sub(1, 4'h0, 0);
    endtask

    task automatic test_reset();
        int n0;
        poc_n = 1'b0;
        repeat (3) @(negedge sysclk);
        poc_n = 1'b1;
        @(negedge sysclk);
        vecs++; if (bus.data_dir !== 1'b0) begin errs++; $display("FAIL rst_dir: got %b want 0", bus.data_dir); end
        vecs++; if (bus.data_out !== 4'h0) begin errs++; $display("FAIL rst_out: got %h want 0", bus.data_out); end
        vecs++; if (io_out !== 4'h7) begin errs++; $display("FAIL rst_io_out: got %h want 7", io_out); end
        vecs++; if (rom_re !== 1'b0) begin errs++; $display("FAIL rst_rom_re: got %b want 0", rom_re); end
        vecs++; if (rom_addr !== 8'h00) begin errs++; $display("FAIL rst_rom_addr: got %h want 00", rom_addr); end
        n0 = rom_re_cnt;
        for (int i = 0; i < 9; i++) begin
            sub(0, 4'(i + 3), 1);
            vecs++; if (bus.data_dir !== 1'b0) begin errs++; $display("FAIL unsync_dir[%0d]: got %b want 0", i, bus.data_dir); end
        end
        vecs++; if (rom_re_cnt - n0 != 0) begin errs++; $display("FAIL unsync_reads: got %0d want 0", rom_re_cnt - n0); end
    endtask

    task automatic test_fetch_hit();
        int n0;
        n0 = rom_re_cnt;
        sub(1, 4'h0, 0);
        sub(0, 4'h5, 0);
        sub(0, 4'hC, 0);
        vecs++; if (rom_re !== 1'b1) begin errs++; $display("FAIL hit_rom_re: got %b want 1", rom_re); end
        vecs++; if (rom_addr !== 8'hC5) begin errs++; $display("FAIL hit_rom_addr: got %h want c5", rom_addr); end
        vecs++; if (bus.data_dir !== 1'b0) begin errs++; $display("FAIL hit_a3_dir: got %b want 0", bus.data_dir); end
        sub(0, 4'h3, 1);
        vecs++; if (bus.data_dir !== 1'b1) begin errs++; $display("FAIL hit_m1_dir: got %b want 1", bus.data_dir); end
        vecs++; if (bus.data_out !== 4'h2) begin errs++; $display("FAIL hit_m1_out: got %h want 2", bus.data_out); end
        sub(0, 4'h0, 0);
        vecs++; if (bus.data_dir !== 1'b1) begin errs++; $display("FAIL hit_m2_dir: got %b want 1", bus.data_dir); end
        vecs++; if (bus.data_out !== 4'hB) begin errs++; $display("FAIL hit_m2_out: got %h want b", bus.data_out); end
        sub(0, 4'h0, 0);
        vecs++; if (bus.data_dir !== 1'b0) begin errs++; $display("FAIL hit_x1_dir: got %b want 0", bus.data_dir); end
        sub(0, 4'h0, 0); sub(0, 4'h0, 0); sub(1, 4'h0, 0);
        vecs++; if (rom_re_cnt - n0 != 1) begin errs++; $display("FAIL hit_read_count: got %0d want 1", rom_re_cnt - n0); end
    endtask

    task automatic test_fetch_miss();
        sub(0, 4'h5, 0); sub(0, 4'hC, 0); sub(0, 4'h4, 1);
        vecs++; if (bus.data_dir !== 1'b0) begin errs++; $display("FAIL miss_m1_dir: got %b want 0", bus.data_dir); end
        sub(0, 4'h7, 0);
        vecs++; if (bus.data_dir !== 1'b0) begin errs++; $display("FAIL miss_m2_dir: got %b want 0", bus.data_dir); end
        sub(0, 4'h1, 0);
        vecs++; if (bus.data_dir !== 1'b0) begin errs++; $display("FAIL miss_x1_dir: got %b want 0", bus.data_dir); end
        sub(0, 4'h0, 0);
        vecs++; if (bus.data_dir !== 1'b0) begin errs++; $display("FAIL miss_x2_dir: got %b want 0", bus.data_dir); end
        sub(0, 4'h0, 0); sub(1, 4'h0, 0);
    endtask

    task automatic test_src_wrr();
        run_cycle(4'h4, 4'h2, 4'h1, 0, 4'h3, 1);
        vecs++; if (io_out !== 4'h7) begin errs++; $display("FAIL src_io_out: got %h want 7", io_out); end
        run_cycle(4'h4, 4'hE, 4'h2, 1, 4'h9, 0);
        vecs++; if (io_out !== 4'h9) begin errs++; $display("FAIL wrr_io_out: got %h want 9", io_out); end
        run_cycle(4'h4, 4'h2, 4'h1, 0, 4'h5, 1);
        run_cycle(4'h4, 4'hE, 4'h2, 1, 4'h4, 0);
        vecs++; if (io_out !== 4'h9) begin errs++; $display("FAIL wrr_unsel_io_out: got %h want 9", io_out); end
    endtask

    task automatic test_rdr();
        run_cycle(4'h4, 4'h2, 4'h1, 0, 4'h3, 1);
        io_in = 4'h6;
        sub(0, 4'h5, 0); sub(0, 4'hC, 0); sub(0, 4'h4, 1);
        sub(0, 4'hE, 0); sub(0, 4'hA, 1);
        vecs++; if (bus.data_dir !== 1'b0) begin errs++; $display("FAIL rdr_x1_dir: got %b want 0", bus.data_dir); end
        sub(0, 4'h0, 0);
        vecs++; if (bus.data_dir !== 1'b1) begin errs++; $display("FAIL rdr_x2_dir: got %b want 1", bus.data_dir); end
        vecs++; if (bus.data_out !== 4'h6) begin errs++; $display("FAIL rdr_x2_out: got %h want 6", bus.data_out); end
        io_in = 4'h1;
        @(negedge sysclk);
        vecs++; if (bus.data_out !== 4'h6) begin errs++; $display("FAIL rdr_hold_out: got %h want 6", bus.data_out); end
        sub(0, 4'h0, 0);
        vecs++; if (bus.data_dir !== 1'b0) begin errs++; $display("FAIL rdr_x3_dir: got %b want 0", bus.data_dir); end
        sub(1, 4'h0, 0);
    endtask

    task automatic test_resync_reset();
        sub(0, 4'h5, 0); sub(0, 4'hC, 0); sub(0, 4'h3, 1);
        vecs++; if (bus.data_dir !== 1'b1) begin errs++; $display("FAIL rs_m1_dir: got %b want 1", bus.data_dir); end
        sub(1, 4'h0, 0);
        vecs++; if (bus.data_dir !== 1'b0) begin errs++; $display("FAIL rs_resync_dir: got %b want 0", bus.data_dir); end
        sub(0, 4'h0, 0); sub(0, 4'h1, 0);
        vecs++; if (rom_addr !== 8'h10) begin errs++; $display("FAIL rs_rom_addr: got %h want 10", rom_addr); end
        sub(0, 4'h3, 1);
        vecs++; if (bus.data_out !== 4'h9) begin errs++; $display("FAIL rs_m1_out: got %h want 9", bus.data_out); end
        sub(0, 4'h0, 0);
        vecs++; if (bus.data_out !== 4'hE || bus.data_dir !== 1'b1) begin errs++; $display("FAIL rs_m2_drive: got dir %b out %h want dir 1 out e", bus.data_dir, bus.data_out); end
        poc_n = 1'b0;
        @(negedge sysclk);
        vecs++; if (bus.data_dir !== 1'b0) begin errs++; $display("FAIL rs_reset_dir: got %b want 0", bus.data_dir); end
        vecs++; if (io_out !== 4'h7) begin errs++; $display("FAIL rs_reset_io_out: got %h want 7", io_out); end
        poc_n = 1'b1;
        @(negedge sysclk);
        sub(0, 4'h3, 1);
        vecs++; if (bus.data_dir !== 1'b0) begin errs++; $display("FAIL rs_post_dir: got %b want 0", bus.data_dir); end
        sub(1, 4'h0, 0);
        sub(0, 4'h5, 0); sub(0, 4'hC, 0); sub(0, 4'h3, 1);
        vecs++; if (bus.data_dir !== 1'b1 || bus.data_out !== 4'h2) begin errs++; $display("FAIL rs_refetch: got dir %b out %h want dir 1 out 2", bus.data_dir, bus.data_out); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 8'(i);
        rom[8'hC5] = 8'h2B;
        rom[8'h10] = 8'h9E;
        poc_n = 1'b0;
        io_in = 4'h0;
        bus.clk1 = 1'b0; bus.clk2 = 1'b0; bus.sync = 1'b0;
        bus.cm_rom = 1'b0; bus.data_in = 4'h0;
        @(negedge sysclk);
        test_reset();
        test_fetch_hit();
        test_fetch_miss();
        test_src_wrr();
        test_rdr();
        test_resync_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
